theta_column_mixer: RTL and testbench

- Column-parity mixing stage that sits directly upstream of the swap (lane permutation) stage in the matrix encoder datapath.
- Accepts one 64-slice block of 25-bit slice lines.
  - Bit i of a line is cell x = i%5, y = i/5.
- Computes column parities across the whole block, XORs each cell with its neighbouring-column parity term, and streams the mixed 64 lines out to the swap stage.
- Two-phase operation: LOAD (buffer block and accumulate parities), then EMIT (stream result).

---
 rtl/theta_column_mixer_if.sv | 37 +++
 rtl/theta_column_mixer.sv | 109 ++++++++++
 tb/tb_theta_column_mixer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/theta_column_mixer_if.sv
// Handshake bundle for theta_column_mixer: LOAD-side input stream, EMIT-side output stream and status.
// THETA_PARITY_OUT_EN adds the per-slice column-parity output.
interface theta_column_mixer_if #(
  parameter int W  = 25,
  parameter int AW = 6
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [AW-1:0] out_index;
  logic          busy;
  logic          done;
`ifdef THETA_PARITY_OUT_EN
  logic [4:0]    out_parity;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, busy, done, out_parity
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, busy, done, out_parity
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, busy, done
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, busy, done
  );
`endif
endinterface

// File: rtl/theta_column_mixer.sv
// Column-parity mixing stage: buffers a DEPTH-slice block of 5x5 lines, then streams theta-mixed lines.
// Optional macro THETA_PARITY_OUT_EN exposes the column parity of the slice being emitted.
module theta_column_mixer #(
  parameter int W     = 25,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input logic              clk,
  input logic              rst,
  theta_column_mixer_if.slave bus
);

  typedef enum logic {
    S_LOAD,
    S_EMIT
  } state_t;

  state_t        state_q;
  logic [AW-1:0] wr_idx_q;
  logic [AW-1:0] rd_idx_q;
  logic          done_q;
  logic [W-1:0]  line_q [DEPTH];
  logic [4:0]    par_q  [DEPTH];

  logic          accept;
  logic [4:0]    in_par_d;
  logic [AW-1:0] prev_idx;
  logic [4:0]    d_mix;
  logic [W-1:0]  out_data_d;

  assign accept = bus.in_valid && (state_q == S_LOAD);

  always_comb begin
    in_par_d = '0;
    for (int unsigned x = 0; x < 5; x++) begin
      for (int unsigned y = 0; y < 5; y++) begin
        in_par_d[x] = in_par_d[x] ^ bus.in_data[5*y+x];
      end
    end
  end

  // Line buffer carries no reset; only the parity array is cleared.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_q[wr_idx_q] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LOAD;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      done_q   <= 1'b0;
      for (int unsigned z = 0; z < DEPTH; z++) begin
        par_q[z] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            par_q[wr_idx_q] <= in_par_d;
            wr_idx_q        <= wr_idx_q + 1'b1;
            if (wr_idx_q == AW'(DEPTH - 1)) begin
              state_q <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            rd_idx_q <= rd_idx_q + 1'b1;
            if (rd_idx_q == AW'(DEPTH - 1)) begin
              state_q <= S_LOAD;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // Index arithmetic wraps at AW bits, so slice 0 picks up the parities of slice DEPTH-1.
  always_comb begin
    prev_idx   = rd_idx_q - 1'b1;
    d_mix      = '0;
    for (int unsigned x = 0; x < 5; x++) begin
      d_mix[x] = par_q[rd_idx_q][(x+4)%5] ^ par_q[prev_idx][(x+1)%5];
    end
    out_data_d = line_q[rd_idx_q];
    for (int unsigned y = 0; y < 5; y++) begin
      for (int unsigned x = 0; x < 5; x++) begin
        out_data_d[5*y+x] = out_data_d[5*y+x] ^ d_mix[x];
      end
    end
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.out_valid = (state_q == S_EMIT);
  assign bus.busy      = (state_q == S_EMIT);
  assign bus.done      = done_q;
  assign bus.out_data  = out_data_d;
  assign bus.out_index = rd_idx_q;
`ifdef THETA_PARITY_OUT_EN
  assign bus.out_parity = par_q[rd_idx_q];
`endif

endmodule

// File: tb/tb_theta_column_mixer.sv
// Directed bench for theta_column_mixer: hand-computed single-bit blocks, wrap-around, stall and mid-block reset.
module tb_theta_column_mixer;
  localparam int W     = 25;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  theta_column_mixer_if #(.W(W), .AW(AW)) bus ();

  theta_column_mixer #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] blk   [DEPTH];
  logic [W-1:0] exp_d [DEPTH];
  logic [4:0]   exp_p [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_block();
    for (int z = 0; z < DEPTH; z++) begin
      blk[z]   = '0;
      exp_d[z] = '0;
      exp_p[z] = '0;
    end
  endtask

  // Independent reference: column parity via lane masks, then per-bit neighbour terms.
  task automatic build_model();
    logic [4:0]   p [DEPTH];
    logic [W-1:0] mask;
    int           zp;
    int           x;
    for (int z = 0; z < DEPTH; z++) begin
      for (int c = 0; c < 5; c++) begin
        mask    = W'(25'h0108421) << c;
        p[z][c] = ^(blk[z] & mask);
      end
    end
    for (int z = 0; z < DEPTH; z++) begin
      zp = (z + DEPTH - 1) % DEPTH;
      for (int i = 0; i < W; i++) begin
        x = i % 5;
        exp_d[z][i] = blk[z][i] ^ p[z][(x+4)%5] ^ p[zp][(x+1)%5];
      end
      exp_p[z] = p[z];
    end
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
`ifdef THETA_PARITY_OUT_EN
    check("rst_parity",    32'(bus.out_parity), 32'd0);
`endif
  endtask

  // Presents n lines back-to-back; optionally keeps in_valid high with junk into EMIT.
  task automatic load_block(input int n, input bit junk);
    for (int z = 0; z < n; z++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = blk[z];
    end
    @(negedge clk);
    if (junk) bus.in_data = '1;
    else      bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input bit stall);
    int           k    = 0;
    int           cyc  = 0;
    int           held = 0;
    int           dcnt = 0;
    logic [W-1:0] hd;
    logic [AW-1:0] hi;
    check({name, "_first_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_first_busy"},  32'(bus.busy),      32'd1);
    check({name, "_first_nrdy"},  32'(bus.in_ready),  32'd0);
    while (k < DEPTH && cyc < 4 * DEPTH) begin
      if (cyc != 0) @(negedge clk);
      cyc++;
      if (bus.done) dcnt++;
      if (stall && k == 10 && held < 3) begin
        bus.out_ready = 1'b0;
        check($sformatf("%s_stall_valid%0d", name, held), 32'(bus.out_valid), 32'd1);
        if (held == 0) begin
          hd = bus.out_data;
          hi = bus.out_index;
          check($sformatf("%s_stall_idx", name), 32'(bus.out_index), 32'd10);
        end else begin
          check($sformatf("%s_stall_data%0d", name, held), 32'(bus.out_data),  32'(hd));
          check($sformatf("%s_stall_idx%0d", name, held),  32'(bus.out_index), 32'(hi));
        end
        held++;
      end else begin
        bus.out_ready = 1'b1;
        if (bus.out_valid) begin
          check($sformatf("%s_idx%0d", name, k),  32'(bus.out_index), 32'(k));
          check($sformatf("%s_data%0d", name, k), 32'(bus.out_data),  32'(exp_d[k]));
`ifdef THETA_PARITY_OUT_EN
          check($sformatf("%s_par%0d", name, k),  32'(bus.out_parity), 32'(exp_p[k]));
`endif
          k++;
        end
      end
    end
    check({name, "_handshakes"}, 32'(k), 32'(DEPTH));
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check({name, "_early_done"}, 32'(dcnt), 32'd0);
    check({name, "_done"},       32'(bus.done),      32'd1);
    check({name, "_done_rdy"},   32'(bus.in_ready),  32'd1);
    check({name, "_end_valid"},  32'(bus.out_valid), 32'd0);
    check({name, "_end_busy"},   32'(bus.busy),      32'd0);
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(bus.done),      32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // 1: all-zero block
    clear_block();
    load_block(DEPTH, 1'b0);
    drain("zero", 1'b0);

    // 2: single bit in slice 0
    clear_block();
    blk[0] = 25'h0000001; exp_d[0] = 25'h0210843; exp_d[1] = 25'h1084210; exp_p[0] = 5'b00001;
    load_block(DEPTH, 1'b0);
    drain("s0", 1'b0);

    // 3: single bit in slice 63 wraps into slice 0
    clear_block();
    blk[63] = 25'h0000001; exp_d[0] = 25'h1084210; exp_d[63] = 25'h0210843; exp_p[63] = 5'b00001;
    load_block(DEPTH, 1'b0);
    drain("wrap", 1'b0);

    // 4: even column parity leaves the block untouched
    clear_block();
    blk[5] = 25'h0000084; exp_d[5] = 25'h0000084;
    load_block(DEPTH, 1'b0);
    drain("even", 1'b0);

    // 5: random block with stall at index 10 and junk on the input during EMIT
    clear_block();
    for (int z = 0; z < DEPTH; z++) blk[z] = W'($urandom);
    build_model();
    load_block(DEPTH, 1'b1);
    drain("rand", 1'b1);

    // 6: reset part way through a block, then pattern 2 again
    clear_block();
    for (int z = 0; z < 20; z++) blk[z] = W'($urandom);
    load_block(20, 1'b0);
    do_reset();
    clear_block();
    blk[0] = 25'h0000001; exp_d[0] = 25'h0210843; exp_d[1] = 25'h1084210; exp_p[0] = 5'b00001;
    load_block(DEPTH, 1'b0);
    drain("rst_s0", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
